lc3b_exec_unit: RTL and testbench

//   LC-3b execute-stage arithmetic block: 16-bit ALU plus PC-relative offset adder with ADJ (sign-extend, <<1).

---
 rtl/lc3b_exec_unit.sv | 81 ++++++++
 tb/tb_lc3b_exec_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lc3b_exec_unit.sv
// LC-3b execute stage: 16-bit ALU plus PC-relative target adder, both captured in stage registers.
// Optional nzp condition-code register enabled by defining EXEC_CC_EN.
module lc3b_exec_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [2:0]       aluop,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] pc,
   input  logic [8:0]       offset9,
   input  logic [10:0]      offset11,
   input  logic             offset_sel,
   output logic [WIDTH-1:0] alu_q,
   output logic [WIDTH-1:0] target_q,
   output logic [WIDTH-1:0] alu_f
`ifdef EXEC_CC_EN
   ,
   output logic [2:0]       cc_q
`endif
);

   logic [WIDTH-1:0] adj;
   logic [WIDTH-1:0] target_next;

   always_comb begin
      alu_f = '0;
      case (aluop)
         3'b000: alu_f = a + b;
         3'b001: alu_f = a & b;
         3'b010: alu_f = ~a;
         3'b011: alu_f = a;
         3'b100: alu_f = a << b[3:0];
         3'b101: alu_f = a >> b[3:0];
         3'b110: alu_f = $unsigned($signed(a) >>> b[3:0]);
         default: alu_f = '0;
      endcase
   end

   // Offset fields are sign-extended and word-aligned (<<1) before the add.
   always_comb begin
      if (offset_sel)
         adj = {{4{offset11[10]}}, offset11, 1'b0};
      else
         adj = {{6{offset9[8]}}, offset9, 1'b0};
      target_next = pc + adj;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_q    <= '0;
         target_q <= '0;
      end else if (load) begin
         alu_q    <= alu_f;
         target_q <= target_next;
      end
   end

`ifdef EXEC_CC_EN
   logic [2:0] cc_next;

   always_comb begin
      if (alu_f[WIDTH-1])
         cc_next = 3'b100;
      else if (alu_f == '0)
         cc_next = 3'b010;
      else
         cc_next = 3'b001;
   end

   always_ff @(posedge clk) begin
      if (reset)
         cc_q <= 3'b010;
      else if (load)
         cc_q <= cc_next;
   end
`endif

endmodule

// File: tb/tb_lc3b_exec_unit.sv
// Scoreboard bench for lc3b_exec_unit: expectations queued at drive time, popped after the capturing edge.
module tb_lc3b_exec_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [2:0]  aluop;
   logic [15:0] a;
   logic [15:0] b;
   logic [15:0] pc;
   logic [8:0]  offset9;
   logic [10:0] offset11;
   logic        offset_sel;
   logic [15:0] alu_q;
   logic [15:0] target_q;
   logic [15:0] alu_f;
`ifdef EXEC_CC_EN
   logic [2:0]  cc_q;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] alu;
      logic [15:0] tgt;
      logic [2:0]  cc;
   } exp_t;

   exp_t sb[$];

   lc3b_exec_unit #(.WIDTH(16)) dut (
      .clk(clk),
      .reset(reset),
      .load(load),
      .aluop(aluop),
      .a(a),
      .b(b),
      .pc(pc),
      .offset9(offset9),
      .offset11(offset11),
      .offset_sel(offset_sel),
      .alu_q(alu_q),
      .target_q(target_q),
      .alu_f(alu_f)
`ifdef EXEC_CC_EN
      ,
      .cc_q(cc_q)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // Behavioural reference: shifts done one bit at a time, offsets via signed integer arithmetic.
   function automatic logic [15:0] model_alu(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
      logic [15:0] r;
      int sh;
      sh = int'(y[3:0]);
      r = x;
      case (op)
         3'd0: r = 16'((32'(x) + 32'(y)) % 65536);
         3'd1: r = x & y;
         3'd2: r = x ^ 16'hFFFF;
         3'd3: r = x;
         3'd4: for (int i = 0; i < sh; i++) r = {r[14:0], 1'b0};
         3'd5: for (int i = 0; i < sh; i++) r = {1'b0, r[15:1]};
         3'd6: for (int i = 0; i < sh; i++) r = {r[15], r[15:1]};
         default: r = 16'h0000;
      endcase
      return r;
   endfunction

   function automatic logic [15:0] model_tgt(input logic [15:0] p, input logic [8:0] o9,
                                             input logic [10:0] o11, input logic sel);
      int off;
      if (sel) off = (int'(o11) >= 1024) ? int'(o11) - 2048 : int'(o11);
      else     off = (int'(o9) >= 256) ? int'(o9) - 512 : int'(o9);
      return 16'((int'(p) + 2 * off + 65536) % 65536);
   endfunction

   function automatic logic [2:0] model_cc(input logic [15:0] r);
      if (r >= 16'h8000) return 3'b100;
      if (r == 16'h0000) return 3'b010;
      return 3'b001;
   endfunction

   function automatic exp_t make_exp(input logic [15:0] al, input logic [15:0] tg);
      exp_t e;
      e.alu = al;
      e.tgt = tg;
      e.cc  = model_cc(al);
      return e;
   endfunction

   task automatic compare_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      check({tag, "_alu_q"}, {16'h0, alu_q}, {16'h0, e.alu});
      check({tag, "_target_q"}, {16'h0, target_q}, {16'h0, e.tgt});
`ifdef EXEC_CC_EN
      check({tag, "_cc_q"}, {29'h0, cc_q}, {29'h0, e.cc});
`endif
      $display("txn %-10s alu_q=%h target_q=%h", tag, alu_q, target_q);
   endtask

   task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] p, input logic [8:0] o9, input logic [10:0] o11, input logic sel);
      logic [15:0] ea;
      aluop = op; a = x; b = y; pc = p; offset9 = o9; offset11 = o11; offset_sel = sel;
      load = 1'b1; reset = 1'b0;
      ea = model_alu(op, x, y);
      #1;
      check({tag, "_alu_f"}, {16'h0, alu_f}, {16'h0, ea});
      sb.push_back(make_exp(ea, model_tgt(p, o9, o11, sel)));
      @(posedge clk); #1;
      compare_out(tag);
   endtask

   initial begin
      logic [15:0] held_alu;
      logic [15:0] held_tgt;
      reset = 1'b1; load = 1'b1; aluop = 3'd0; a = 16'h1234; b = 16'h1111;
      pc = 16'h3000; offset9 = 9'h010; offset11 = 11'h010; offset_sel = 1'b0;
      @(posedge clk); #1;
      sb.push_back(make_exp(16'h0000, 16'h0000));
      compare_out("reset");

      do_op("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 16'h3000, 9'h000, 11'h000, 1'b0);
      do_op("and",      3'd1, 16'hF0F0, 16'h3CFF, 16'h3000, 9'h1FF, 11'h000, 1'b0);
      do_op("sra",      3'd6, 16'h8000, 16'h0004, 16'h3000, 9'h000, 11'h3FF, 1'b1);
      do_op("srl",      3'd5, 16'h8000, 16'h0004, 16'h3000, 9'h0FF, 11'h000, 1'b0);
      do_op("sll15",    3'd4, 16'h0001, 16'h001F, 16'h3000, 9'h100, 11'h000, 1'b0);
      do_op("sll0",     3'd4, 16'hA5A5, 16'hFFF0, 16'h0000, 9'h000, 11'h400, 1'b1);
      do_op("not",      3'd2, 16'h00FF, 16'h0000, 16'hFFFE, 9'h001, 11'h000, 1'b0);
      do_op("pass",     3'd3, 16'h8000, 16'h1234, 16'h0002, 9'h1FE, 11'h7FF, 1'b1);
      do_op("zero",     3'd7, 16'hFFFF, 16'hFFFF, 16'h1000, 9'h000, 11'h000, 1'b0);
      do_op("pass_z",   3'd3, 16'h0000, 16'h0000, 16'h1000, 9'h000, 11'h000, 1'b0);
      do_op("pass_p",   3'd3, 16'h0001, 16'h0000, 16'h1000, 9'h000, 11'h000, 1'b0);

      // Stall: outputs hold while alu_f follows the changing inputs.
      held_alu = alu_q;
      held_tgt = target_q;
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         aluop = 3'($urandom_range(0, 6)); a = 16'($urandom); b = 16'($urandom);
         pc = 16'($urandom); offset9 = 9'($urandom); offset11 = 11'($urandom); offset_sel = 1'($urandom);
         #1;
         check("hold_alu_f", {16'h0, alu_f}, {16'h0, model_alu(aluop, a, b)});
         sb.push_back(make_exp(held_alu, held_tgt));
         @(posedge clk); #1;
         compare_out("hold");
      end

      for (int i = 0; i < 24; i++) begin
         do_op("rand", 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 16'($urandom),
               9'($urandom), 11'($urandom), 1'($urandom));
      end

      reset = 1'b1; load = 1'b1; aluop = 3'd3; a = 16'hFFFF;
      @(posedge clk); #1;
      sb.push_back(make_exp(16'h0000, 16'h0000));
      compare_out("reset2");
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
